// File: rtl/stamp_capture_arbiter_pkg.sv
// Shared widths and the FIFO entry layout for the stamp capture path.
package stamp_capture_arbiter_pkg;

    localparam int unsigned NUM_QUEUES  = 8;
    localparam int unsigned NUM_PORTS   = NUM_QUEUES / 2;
    localparam int unsigned STAMP_WIDTH = 64;
    localparam int unsigned SRC_WIDTH   = $clog2(NUM_QUEUES);
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned DROP_WIDTH  = 32;
    localparam int unsigned DROP_INC_W  = $clog2(NUM_QUEUES + 1);

    // Requester id: rx port p -> p, tx port p -> NUM_PORTS + p.
    typedef logic [SRC_WIDTH-1:0] src_t;

    typedef struct packed {
        src_t                   src;
        logic [STAMP_WIDTH-1:0] data;
    } stamp_entry_t;

    localparam int unsigned ENTRY_WIDTH = $bits(stamp_entry_t);

endpackage

// File: rtl/stamp_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit.
module stamp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointer compare: equal -> empty, equal index with differing wrap bit -> full.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr[AW-1:0]];
    end

    // Storage and pointer update; storage cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/stamp_capture_arbiter.sv
// Per-requester timestamp snapshots, round-robin drain into a shared FWFT FIFO.
module stamp_capture_arbiter
    import stamp_capture_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   valid_rx,
    input  logic [NUM_PORTS-1:0]   valid_tx,
    input  logic [STAMP_WIDTH-1:0] counter_val,
    output logic                   stamp_vld,
    input  logic                   stamp_rdy,
    output logic [STAMP_WIDTH-1:0] stamp_data,
    output logic [SRC_WIDTH-1:0]   stamp_src,
    output logic [DROP_WIDTH-1:0]  drop_count,
    input  logic                   drop_clr
);

    logic [NUM_QUEUES-1:0]  req;
    logic [NUM_QUEUES-1:0]  pending;
    logic [NUM_QUEUES-1:0]  pending_nxt;
    logic [NUM_QUEUES-1:0]  grant;
    logic [NUM_QUEUES-1:0]  load;
    logic [NUM_QUEUES-1:0]  drop;
    logic [STAMP_WIDTH-1:0] snap [NUM_QUEUES];
    src_t                   rr_ptr;
    src_t                   grant_id;
    src_t                   scan_idx;
    logic                   grant_any;
    logic                   fifo_full;
    logic                   fifo_empty;
    stamp_entry_t           push_entry;
    stamp_entry_t           head_entry;
    logic [DROP_INC_W-1:0]  drop_inc;
    logic [DROP_WIDTH:0]    drop_sum;
    logic [DROP_WIDTH-1:0]  drop_nxt;

    assign req = {valid_tx, valid_rx};

    // Round-robin search from rr_ptr upward with wrap; no grant while the FIFO is full.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = rr_ptr;
        if (!fifo_full) begin
            for (int k = 0; k < int'(NUM_QUEUES); k++) begin
                scan_idx = rr_ptr + SRC_WIDTH'(k);
                if (!grant_any && pending[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_id  = scan_idx;
                end
            end
        end
        grant = NUM_QUEUES'(grant_any) << grant_id;
    end

    // Slot bookkeeping: a slot being drained this cycle can accept a new snapshot.
    always_comb begin
        load        = req & (~pending | grant);
        drop        = req & pending & ~grant;
        pending_nxt = req | (pending & ~grant);
        drop_inc    = DROP_INC_W'($countones(drop));
        drop_sum    = {1'b0, drop_count} + (DROP_WIDTH + 1)'(drop_inc);
        drop_nxt    = drop_count;
        if (drop_clr) begin
            drop_nxt = DROP_WIDTH'(drop_inc);
        end else if (drop_sum[DROP_WIDTH]) begin
            drop_nxt = '1;
        end else begin
            drop_nxt = drop_sum[DROP_WIDTH-1:0];
        end
        push_entry.src  = grant_id;
        push_entry.data = snap[grant_id];
    end

    // Control state: pending vector, arbiter pointer, saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            rr_ptr     <= '0;
            drop_count <= '0;
        end else begin
            pending    <= pending_nxt;
            drop_count <= drop_nxt;
            if (grant_any) begin
                rr_ptr <= grant_id + SRC_WIDTH'(1);
            end
        end
    end

    // Snapshot registers capture the counter in the request cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_QUEUES); i++) begin
            if (load[i]) begin
                snap[i] <= counter_val;
            end
        end
    end

    stamp_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant_any),
        .push_data (push_entry),
        .pop       (stamp_rdy),
        .head      (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign stamp_vld  = !fifo_empty;
    assign stamp_data = head_entry.data;
    assign stamp_src  = head_entry.src;

endmodule

// File: tb/tb_stamp_capture_arbiter.sv
// Directed bench for stamp_capture_arbiter with an in-order scoreboard on the output port.
module tb_stamp_capture_arbiter;
    import stamp_capture_arbiter_pkg::*;

    logic                   clk;
    logic                   reset;
    logic [NUM_PORTS-1:0]   valid_rx;
    logic [NUM_PORTS-1:0]   valid_tx;
    logic [STAMP_WIDTH-1:0] counter_val;
    logic                   stamp_vld;
    logic                   stamp_rdy;
    logic [STAMP_WIDTH-1:0] stamp_data;
    logic [SRC_WIDTH-1:0]   stamp_src;
    logic [DROP_WIDTH-1:0]  drop_count;
    logic                   drop_clr;

    int vectors     = 0;
    int miscompares = 0;

    stamp_entry_t sb[$];

    stamp_capture_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .valid_rx    (valid_rx),
        .valid_tx    (valid_tx),
        .counter_val (counter_val),
        .stamp_vld   (stamp_vld),
        .stamp_rdy   (stamp_rdy),
        .stamp_data  (stamp_data),
        .stamp_src   (stamp_src),
        .drop_count  (drop_count),
        .drop_clr    (drop_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_stamp(input int src, input logic [63:0] data);
        stamp_entry_t e;
        e.src  = SRC_WIDTH'(src);
        e.data = data;
        sb.push_back(e);
    endtask

    // One-cycle request pulse; the counter moves on afterwards so late capture shows up.
    task automatic pulse(input logic [3:0] rx, input logic [3:0] tx, input logic [63:0] cv);
        valid_rx    = rx;
        valid_tx    = tx;
        counter_val = cv;
        tick();
        valid_rx    = '0;
        valid_tx    = '0;
        counter_val = cv + 64'h1000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Compare every accepted head against the scoreboard front.
    always @(negedge clk) begin
        if (!reset && stamp_vld && stamp_rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_stamp", 64'(stamp_src), 64'hDEAD);
            end else begin
                stamp_entry_t e;
                e = sb.pop_front();
                check("sb_src", 64'(stamp_src), 64'(e.src));
                check("sb_data", stamp_data, e.data);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        valid_rx    = '0;
        valid_tx    = '0;
        counter_val = '0;
        stamp_rdy   = 1'b1;
        drop_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        check("rst_vld", 64'(stamp_vld), 64'h0);
        check("rst_data", stamp_data, 64'h0);
        check("rst_src", 64'(stamp_src), 64'h0);
        check("rst_drop", 64'(drop_count), 64'h0);

        // Single rx request: two-cycle latency
        expect_stamp(0, 64'h10);
        pulse(4'b0001, 4'b0000, 64'h10);
        check("lat_vld_early", 64'(stamp_vld), 64'h0);
        tick();
        check("lat_vld", 64'(stamp_vld), 64'h1);
        check("lat_data", stamp_data, 64'h10);
        check("lat_src", 64'(stamp_src), 64'h0);
        check("lat_drop", 64'(drop_count), 64'h0);
        repeat (3) tick();

        // All eight at once from rr_ptr 0: eight back-to-back outputs
        do_reset();
        for (int i = 0; i < 8; i++) expect_stamp(i, 64'h55);
        pulse(4'hF, 4'hF, 64'h55);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("burst_vld", 64'(stamp_vld), 64'h1);
            tick();
        end
        check("burst_end_vld", 64'(stamp_vld), 64'h0);

        // Fairness: after 5 is granted, 6 goes before 2
        expect_stamp(5, 64'h5A);
        pulse(4'b0000, 4'b0010, 64'h5A);
        expect_stamp(6, 64'h66);
        expect_stamp(2, 64'h66);
        pulse(4'b0100, 4'b0100, 64'h66);
        repeat (6) tick();

        // Back-pressure: fill FIFO, fifth slot pends, second pulse on it drops
        stamp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_stamp(i, 64'h71 + 64'(i));
            pulse(4'(1 << i), 4'b0000, 64'h71 + 64'(i));
        end
        expect_stamp(4, 64'h75);
        pulse(4'b0000, 4'b0001, 64'h75);
        pulse(4'b0000, 4'b0001, 64'h76);
        check("bp_drop", 64'(drop_count), 64'h1);
        check("bp_hold_vld", 64'(stamp_vld), 64'h1);
        check("bp_hold_src", 64'(stamp_src), 64'h0);
        check("bp_hold_data", stamp_data, 64'h71);
        repeat (2) tick();
        check("bp_stable_src", 64'(stamp_src), 64'h0);
        check("bp_stable_data", stamp_data, 64'h71);
        stamp_rdy = 1'b1;
        repeat (8) tick();
        check("bp_drained_vld", 64'(stamp_vld), 64'h0);
        check("bp_drop_kept", 64'(drop_count), 64'h1);

        // Clear, then grant and new request on id 3 in the same cycle
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        check("clr_drop", 64'(drop_count), 64'h0);
        expect_stamp(3, 64'h80);
        pulse(4'b1000, 4'b0000, 64'h80);
        expect_stamp(3, 64'h81);
        pulse(4'b1000, 4'b0000, 64'h81);
        repeat (5) tick();
        check("same_id_drop", 64'(drop_count), 64'h0);

        // drop_clr together with a drop leaves exactly one
        expect_stamp(0, 64'h90);
        expect_stamp(1, 64'h90);
        pulse(4'b0011, 4'b0000, 64'h90);
        drop_clr = 1'b1;
        pulse(4'b0010, 4'b0000, 64'h91);
        drop_clr = 1'b0;
        check("clr_with_drop", 64'(drop_count), 64'h1);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        check("clr_alone", 64'(drop_count), 64'h0);
        repeat (4) tick();

        // Reset with three queued entries and two pending; reset-cycle request ignored
        stamp_rdy = 1'b0;
        pulse(4'b1111, 4'b0001, 64'hA0);
        repeat (3) tick();
        check("pre_rst_vld", 64'(stamp_vld), 64'h1);
        reset    = 1'b1;
        valid_rx = 4'b0001;
        tick();
        reset    = 1'b0;
        valid_rx = '0;
        check("mid_rst_vld", 64'(stamp_vld), 64'h0);
        check("mid_rst_data", stamp_data, 64'h0);
        check("mid_rst_drop", 64'(drop_count), 64'h0);
        stamp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("no_stale_vld", 64'(stamp_vld), 64'h0);
            tick();
        end

        check("sb_empty", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
